dfi_access_checker: RTL and testbench
=====================================

# dfi_access_checker

Consumer stage directly downstream of `dfg_controller`. Accepts one observed memory-write event at a time from the bus trace monitor: write address, write data, and the pointer-table index of the writing instruction. Drives the controller's reload and step inputs to walk the allowed DFG entries for that index. Reports a pass when an entry matches address and data range, or a violation when the entries are exhausted, the index is invalid, or the step budget runs out.

## Interface
- `N_ADDR_WIDTH`, 32, width of address, data and DFG entry fields
- `N_PTR_WIDTH`, 8, width of pointer-table index
- `N_PTR_LINES`, 6, highest valid pointer-table index
- `N_MAX_STEPS`, 16, step budget per event (watchdog); ≥1
- `clk` in 1, clock
- `rst` in 1, reset, synchronous, active-low
- `i_acc_valid` in 1, event valid
- `o_acc_ready` out 1, checker idle and able to accept
- `i_acc_addr` in N_ADDR_WIDTH, observed write address
- `i_acc_data` in N_ADDR_WIDTH, observed write data
- `i_acc_idx` in N_PTR_WIDTH, pointer-table index of the writing instruction
- `o_addr_srch` out N_PTR_WIDTH, index to controller; held for the whole transaction
- `o_clr` out 1, controller reload, active-low
- `o_srch_pulse` out 1, controller step, one cycle
- `i_addr_DFG`, `i_data_init`, `i_data_end` in N_ADDR_WIDTH each, current controller entry
- `i_error` in 1, controller error (entries exhausted or index invalid)
- `o_pass` out 1, one-cycle pass pulse
- `o_violation` out 1, violation flag (see Configuration)
- `o_viol_cause` out 2, 0 none, 1 no match, 2 bad index, 3 timeout
- `o_viol_addr`, `o_viol_data` out N_ADDR_WIDTH, event captured at the last violation
- `i_viol_ack` in 1, clears the sticky flag (used only with the macro)

## Operation
- States: IDLE, LOAD, SETTLE, STEP, CMP, DONE.
- IDLE:
  - `o_acc_ready`=1.
  - On `i_acc_valid`: latch addr, data and idx; clear the step counter; go to LOAD.
  - If idx > N_PTR_LINES: go to DONE with cause 2 and no controller access.
- LOAD: `o_clr`=0 for exactly one cycle → SETTLE.
- SETTLE: one cycle while the controller recomputes its pointers → STEP.
- STEP: `o_srch_pulse`=1 for one cycle; step counter +1 → CMP.
- CMP: evaluate in this priority order.
  - `i_error` → DONE, cause 1.
  - `i_addr_DFG`==addr and `i_data_init` ≤ data ≤ `i_data_end` (unsigned, inclusive) → DONE, pass.
  - step counter == N_MAX_STEPS → DONE, cause 3.
  - Otherwise → STEP.
- DONE:
  - Pass: one-cycle `o_pass`.
  - Violation: `o_violation`, with `o_viol_cause`, `o_viol_addr` and `o_viol_data` updated.
  - Then → IDLE.
- The entry at controller line 0 is never compared. The first STEP after reload moves the controller from ptr−1 to its first entry.
- `o_clr`=1 and `o_srch_pulse`=0 in every state except as stated above.
- A new event is never accepted while not in IDLE; `i_acc_*` are don't-care there.

## Timing
- Reset values:
  - state IDLE; `o_acc_ready`=1; `o_clr`=1.
  - `o_srch_pulse`=0; `o_pass`=0; `o_violation`=0.
  - `o_viol_cause`=0; `o_viol_addr`=0; `o_viol_data`=0; `o_addr_srch`=0.
- Reset mid-transaction aborts with no pass or violation.
- All outputs are registered.
- With the event accepted at edge E0:
  - LOAD in cycle 1, SETTLE in cycle 2.
  - Entry k is stepped in cycle 1+2k and compared in cycle 2+2k.
  - The result is visible in cycle 3+2k; `o_acc_ready` returns in cycle 4+2k.
- Bad index: result in cycle 2.
- Controller contract: `i_addr_DFG`, `i_data_init`, `i_data_end` and `i_error` are valid combinationally in CMP. They are sampled only in CMP.

## Configuration
- `DFI_STICKY_VIOLATION_EN` defined:
  - `o_violation` stays high from DONE until a cycle with `i_viol_ack`=1.
  - Further violations update cause, addr and data.
  - An ack in the same cycle as a new violation leaves the flag set.
- Not defined: `o_violation` is a one-cycle pulse and `i_viol_ack` is ignored.

## Structure
- Shared package `dfi_pkg`: state encoding and the cause constants (CAUSE_NONE=0, CAUSE_NOMATCH=1, CAUSE_BADIDX=2, CAUSE_TIMEOUT=3).
- One sub-module, `dfi_range_cmp`: combinational address-equal and data-in-range compare. Reused by later checkers.

## Test plan
- Index 2, table entries {0x1000,[0,0xFF]} and {0x2000,[0x10,0x20]}; event addr 0x2000, data 0x15 → `o_pass` at cycle 7; two `o_srch_pulse`; one `o_clr` low.
- Same table; data 0x21 → `o_violation`, cause 1, `o_viol_addr`=0x2000, `o_viol_data`=0x21, after the third step.
- Index 7 with N_PTR_LINES=6 → cause 2 at cycle 2; `o_clr` and `o_srch_pulse` never asserted.
- N_MAX_STEPS=2 with 4 non-matching entries → cause 3 after the second compare.
- Two back-to-back events with `i_acc_valid` held high → second accepted only in the cycle `o_acc_ready` rises; `o_addr_srch` changes only at acceptance.
- With the macro defined: violation, then `i_viol_ack` 5 cycles later → flag stays high 5 cycles, low the next cycle. Without the macro: a one-cycle pulse.

Source files
------------

// File: rtl/dfi_pkg.sv
// Shared types for the DFI access checker family: checker FSM states and
// violation cause codes reported on o_viol_cause.
package dfi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_STEP,
    S_CMP,
    S_DONE
  } dfi_state_t;

  typedef logic [1:0] dfi_cause_t;

  localparam dfi_cause_t CAUSE_NONE    = 2'd0;
  localparam dfi_cause_t CAUSE_NOMATCH = 2'd1;
  localparam dfi_cause_t CAUSE_BADIDX  = 2'd2;
  localparam dfi_cause_t CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/dfi_range_cmp.sv
// Combinational DFG entry compare: exact address match and unsigned,
// inclusive data-range check against [i_data_init, i_data_end].
module dfi_range_cmp #(
  parameter int unsigned N_ADDR_WIDTH = 32
) (
  input  logic [N_ADDR_WIDTH-1:0] i_addr,
  input  logic [N_ADDR_WIDTH-1:0] i_data,
  input  logic [N_ADDR_WIDTH-1:0] i_addr_DFG,
  input  logic [N_ADDR_WIDTH-1:0] i_data_init,
  input  logic [N_ADDR_WIDTH-1:0] i_data_end,
  output logic                    o_addr_eq,
  output logic                    o_in_range,
  output logic                    o_match
);

  always_comb begin
    o_addr_eq  = (i_addr == i_addr_DFG);
    o_in_range = (i_data >= i_data_init) && (i_data <= i_data_end);
    o_match    = o_addr_eq && o_in_range;
  end

endmodule

// File: rtl/dfi_access_checker.sv
// Walks the dfg_controller entries for one observed write and reports pass or
// violation. Optional macro DFI_STICKY_VIOLATION_EN makes o_violation sticky until i_viol_ack.
module dfi_access_checker
  import dfi_pkg::*;
#(
  parameter int unsigned N_ADDR_WIDTH = 32,
  parameter int unsigned N_PTR_WIDTH  = 8,
  parameter int unsigned N_PTR_LINES  = 6,
  parameter int unsigned N_MAX_STEPS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_acc_valid,
  output logic                    o_acc_ready,
  input  logic [N_ADDR_WIDTH-1:0] i_acc_addr,
  input  logic [N_ADDR_WIDTH-1:0] i_acc_data,
  input  logic [N_PTR_WIDTH-1:0]  i_acc_idx,
  output logic [N_PTR_WIDTH-1:0]  o_addr_srch,
  output logic                    o_clr,
  output logic                    o_srch_pulse,
  input  logic [N_ADDR_WIDTH-1:0] i_addr_DFG,
  input  logic [N_ADDR_WIDTH-1:0] i_data_init,
  input  logic [N_ADDR_WIDTH-1:0] i_data_end,
  input  logic                    i_error,
  output logic                    o_pass,
  output logic                    o_violation,
  output logic [1:0]              o_viol_cause,
  output logic [N_ADDR_WIDTH-1:0] o_viol_addr,
  output logic [N_ADDR_WIDTH-1:0] o_viol_data,
  input  logic                    i_viol_ack
);

  localparam int unsigned CNT_W = $clog2(N_MAX_STEPS + 1);
  localparam logic [N_PTR_WIDTH-1:0] MAX_IDX    = N_PTR_LINES[N_PTR_WIDTH-1:0];
  localparam logic [CNT_W-1:0]       STEP_LIMIT = N_MAX_STEPS[CNT_W-1:0];

  dfi_state_t              r_state;
  dfi_state_t              w_next;
  logic [N_ADDR_WIDTH-1:0] r_addr;
  logic [N_ADDR_WIDTH-1:0] r_data;
  logic                    r_badidx;
  logic [CNT_W-1:0]        r_steps;

  logic       w_accept;
  logic       w_idx_bad;
  logic       w_addr_eq;
  logic       w_in_range;
  logic       w_match;
  logic       w_pass;
  logic       w_viol;
  dfi_cause_t w_cause;

  assign w_accept  = (r_state == S_IDLE) && i_acc_valid;
  assign w_idx_bad = (i_acc_idx > MAX_IDX);

  dfi_range_cmp #(
    .N_ADDR_WIDTH(N_ADDR_WIDTH)
  ) u_range_cmp (
    .i_addr      (r_addr),
    .i_data      (r_data),
    .i_addr_DFG  (i_addr_DFG),
    .i_data_init (i_data_init),
    .i_data_end  (i_data_end),
    .o_addr_eq   (w_addr_eq),
    .o_in_range  (w_in_range),
    .o_match     (w_match)
  );

  // A bad index passes through SETTLE (no controller strobes) so its result
  // lands two cycles after acceptance, like the registered-output path expects.
  always_comb begin
    w_next  = r_state;
    w_pass  = 1'b0;
    w_viol  = 1'b0;
    w_cause = CAUSE_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (i_acc_valid) w_next = w_idx_bad ? S_SETTLE : S_LOAD;
      end
      S_LOAD: w_next = S_SETTLE;
      S_SETTLE: begin
        if (r_badidx) begin
          w_next  = S_DONE;
          w_viol  = 1'b1;
          w_cause = CAUSE_BADIDX;
        end else begin
          w_next = S_STEP;
        end
      end
      S_STEP: w_next = S_CMP;
      S_CMP: begin
        if (i_error) begin
          w_next  = S_DONE;
          w_viol  = 1'b1;
          w_cause = CAUSE_NOMATCH;
        end else if (w_match) begin
          w_next = S_DONE;
          w_pass = 1'b1;
        end else if (r_steps == STEP_LIMIT) begin
          w_next  = S_DONE;
          w_viol  = 1'b1;
          w_cause = CAUSE_TIMEOUT;
        end else begin
          w_next = S_STEP;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe coincides with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_badidx     <= 1'b0;
      r_steps      <= '0;
      o_acc_ready  <= 1'b1;
      o_addr_srch  <= '0;
      o_clr        <= 1'b1;
      o_srch_pulse <= 1'b0;
      o_pass       <= 1'b0;
      o_violation  <= 1'b0;
      o_viol_cause <= CAUSE_NONE;
      o_viol_addr  <= '0;
      o_viol_data  <= '0;
    end else begin
      r_state      <= w_next;
      o_acc_ready  <= (w_next == S_IDLE);
      o_clr        <= (w_next != S_LOAD);
      o_srch_pulse <= (w_next == S_STEP);
      o_pass       <= w_pass;
      if (w_accept) begin
        r_addr      <= i_acc_addr;
        r_data      <= i_acc_data;
        r_badidx    <= w_idx_bad;
        r_steps     <= '0;
        o_addr_srch <= i_acc_idx;
      end
      if (r_state == S_STEP) r_steps <= r_steps + 1'b1;
      if (w_viol) begin
        o_viol_cause <= w_cause;
        o_viol_addr  <= r_addr;
        o_viol_data  <= r_data;
      end
`ifdef DFI_STICKY_VIOLATION_EN
      if (w_viol) o_violation <= 1'b1;
      else if (i_viol_ack) o_violation <= 1'b0;
`else
      o_violation <= w_viol;
`endif
    end
  end

`ifndef DFI_STICKY_VIOLATION_EN
  logic w_unused_ack;
  assign w_unused_ack = i_viol_ack;
`endif

endmodule

// File: tb/tb_dfi_access_checker.sv
// Self-checking bench for dfi_access_checker with a behavioural dfg_controller
// and a table-walk reference model; covers both builds of DFI_STICKY_VIOLATION_EN.
module tb_dfi_access_checker;

  localparam int unsigned AW    = 32;
  localparam int unsigned PW    = 8;
  localparam int unsigned LINES = 6;
  localparam int unsigned MAXS  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_acc_valid = 1'b0;
  logic          o_acc_ready;
  logic [AW-1:0] i_acc_addr = '0;
  logic [AW-1:0] i_acc_data = '0;
  logic [PW-1:0] i_acc_idx = '0;
  logic [PW-1:0] o_addr_srch;
  logic          o_clr;
  logic          o_srch_pulse;
  logic [AW-1:0] ctl_addr;
  logic [AW-1:0] ctl_lo;
  logic [AW-1:0] ctl_hi;
  logic          ctl_err;
  logic          o_pass;
  logic          o_violation;
  logic [1:0]    o_viol_cause;
  logic [AW-1:0] o_viol_addr;
  logic [AW-1:0] o_viol_data;
  logic          i_viol_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dfi_access_checker #(
    .N_ADDR_WIDTH(AW),
    .N_PTR_WIDTH (PW),
    .N_PTR_LINES (LINES),
    .N_MAX_STEPS (MAXS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_acc_valid  (i_acc_valid),
    .o_acc_ready  (o_acc_ready),
    .i_acc_addr   (i_acc_addr),
    .i_acc_data   (i_acc_data),
    .i_acc_idx    (i_acc_idx),
    .o_addr_srch  (o_addr_srch),
    .o_clr        (o_clr),
    .o_srch_pulse (o_srch_pulse),
    .i_addr_DFG   (ctl_addr),
    .i_data_init  (ctl_lo),
    .i_data_end   (ctl_hi),
    .i_error      (ctl_err),
    .o_pass       (o_pass),
    .o_violation  (o_violation),
    .o_viol_cause (o_viol_cause),
    .o_viol_addr  (o_viol_addr),
    .o_viol_data  (o_viol_data),
    .i_viol_ack   (i_viol_ack)
  );

  // Controller model: per-index entry lists; pos 0 is "before the first entry".
  int          tbl_n  [8];
  logic [31:0] tbl_a  [8][8];
  logic [31:0] tbl_lo [8][8];
  logic [31:0] tbl_hi [8][8];
  int          pos = 0;
  logic [2:0]  w_line;
  logic [2:0]  w_ent;

  always @(posedge clk) begin
    if (!o_clr) pos <= 0;
    else if (o_srch_pulse) pos <= pos + 1;
  end

  assign w_line   = o_addr_srch[2:0];
  assign w_ent    = 3'(pos - 1);
  assign ctl_addr = tbl_a[w_line][w_ent];
  assign ctl_lo   = tbl_lo[w_line][w_ent];
  assign ctl_hi   = tbl_hi[w_line][w_ent];
  assign ctl_err  = (o_addr_srch > 8'd6) || (pos == 0) || (pos > tbl_n[w_line]);

  typedef struct {
    int          kind;    // 0 pass, 1 no match, 2 bad index, 3 timeout
    int          res;     // cycle after acceptance where the result shows
    int          rdy;
    int          pulses;
    int          clrs;
    int          npass;
    logic [31:0] va;
    logic [31:0] vd;
    bit          srch_ok;
  } obs_t;

  function automatic obs_t predict(input int idx, input logic [31:0] a, input logic [31:0] d);
    obs_t e;
    int   k;
    e.va = a; e.vd = d; e.srch_ok = 1'b1; e.npass = 0;
    if (idx > int'(LINES)) begin
      e.kind = 2; e.res = 2; e.rdy = 3; e.pulses = 0; e.clrs = 0;
      return e;
    end
    e.kind = -1;
    k = 0;
    for (int s = 1; s <= int'(MAXS) && e.kind < 0; s++) begin
      k = s;
      if (s > tbl_n[idx]) e.kind = 1;
      else if (tbl_a[idx][s-1] == a && tbl_lo[idx][s-1] <= d && d <= tbl_hi[idx][s-1]) e.kind = 0;
      else if (s == int'(MAXS)) e.kind = 3;
    end
    e.res = 3 + 2 * k; e.rdy = 4 + 2 * k; e.pulses = k; e.clrs = 1;
    e.npass = (e.kind == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic set_entry(input int idx, input int j, input logic [31:0] a,
                           input logic [31:0] lo, input logic [31:0] hi);
    tbl_a[idx][j] = a; tbl_lo[idx][j] = lo; tbl_hi[idx][j] = hi;
  endtask

  // Drives one event and collects what the DUT did, cycle 1 being the cycle after acceptance.
  task automatic run_event(input logic [7:0] idx, input logic [31:0] a, input logic [31:0] d,
                           output obs_t o);
    int wait_n = 0;
    o.kind = -1; o.res = -1; o.rdy = -1; o.pulses = 0; o.clrs = 0; o.npass = 0;
    o.va = '0; o.vd = '0; o.srch_ok = 1'b1;
    @(negedge clk); i_viol_ack = 1'b1;
    @(negedge clk); i_viol_ack = 1'b0;
    while (!o_acc_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    i_acc_valid = 1'b1; i_acc_idx = idx; i_acc_addr = a; i_acc_data = d;
    @(negedge clk);
    i_acc_valid = 1'b0; i_acc_idx = 8'($urandom); i_acc_addr = $urandom; i_acc_data = $urandom;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (o_pass) o.npass++;
      if (o.res < 0 && o_pass) begin o.res = cyc; o.kind = 0; end
      else if (o.res < 0 && o_violation) begin
        o.res = cyc; o.kind = int'(o_viol_cause); o.va = o_viol_addr; o.vd = o_viol_data;
      end
      if (o_srch_pulse) o.pulses++;
      if (!o_clr) o.clrs++;
      if (o_addr_srch !== idx) o.srch_ok = 1'b0;
      if (o_acc_ready) begin o.rdy = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic load_plan_tables();
    for (int i = 0; i < 8; i++) tbl_n[i] = 0;
    tbl_n[2] = 2;
    set_entry(2, 0, 32'h1000, 32'h0, 32'hFF);
    set_entry(2, 1, 32'h2000, 32'h10, 32'h20);
    tbl_n[3] = 6;
    for (int j = 0; j < 6; j++) set_entry(3, j, 32'h3000, 32'h100, 32'h1FF);
    tbl_n[4] = 4;
    for (int j = 0; j < 3; j++) set_entry(4, j, 32'h4444, 32'h0, 32'hFFFF);
    set_entry(4, 3, 32'h4000, 32'h40, 32'h50);
    tbl_n[6] = 1;
    set_entry(6, 0, 32'h6000, 32'h5, 32'h9);
    tbl_n[0] = 1;
    set_entry(0, 0, 32'h7000, 32'h30, 32'h2F);
    tbl_n[1] = 1;
    set_entry(1, 0, 32'h5000, 32'h0, 32'hFFFF);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_acc_ready, o_clr, o_srch_pulse, o_pass, o_violation} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_flags got %b want 11000", {o_acc_ready, o_clr, o_srch_pulse, o_pass, o_violation});
    end
    n_checks++;
    if ({o_viol_cause, o_viol_addr, o_viol_data, o_addr_srch} !== '0) begin
      n_fail++; $display("FAIL reset_data got cause=%0d addr=%h data=%h srch=%0d want all 0", o_viol_cause, o_viol_addr, o_viol_data, o_addr_srch);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    obs_t o;
    run_event(8'd2, 32'h2000, 32'h15, o);
    n_checks++; if (o.kind !== 0) begin n_fail++; $display("FAIL pass_kind got %0d want 0", o.kind); end
    n_checks++; if (o.res !== 7) begin n_fail++; $display("FAIL pass_cycle got %0d want 7", o.res); end
    n_checks++; if (o.pulses !== 2) begin n_fail++; $display("FAIL pass_steps got %0d want 2", o.pulses); end
    n_checks++; if (o.clrs !== 1) begin n_fail++; $display("FAIL pass_clr got %0d want 1", o.clrs); end
    n_checks++; if (o.rdy !== 8) begin n_fail++; $display("FAIL pass_ready got %0d want 8", o.rdy); end
    n_checks++; if (o.srch_ok !== 1'b1) begin n_fail++; $display("FAIL pass_srch got 0 want 1"); end
  endtask

  task automatic test_nomatch();
    obs_t o;
    run_event(8'd2, 32'h2000, 32'h21, o);
    n_checks++; if (o.kind !== 1) begin n_fail++; $display("FAIL nomatch_cause got %0d want 1", o.kind); end
    n_checks++; if (o.res !== 9) begin n_fail++; $display("FAIL nomatch_cycle got %0d want 9", o.res); end
    n_checks++; if (o.pulses !== 3) begin n_fail++; $display("FAIL nomatch_steps got %0d want 3", o.pulses); end
    n_checks++;
    if (o.va !== 32'h2000 || o.vd !== 32'h21) begin
      n_fail++; $display("FAIL nomatch_capture got %h/%h want 00002000/00000021", o.va, o.vd);
    end
  endtask

  task automatic test_bad_index();
    obs_t o;
    run_event(8'd7, 32'hABCD, 32'h99, o);
    n_checks++; if (o.kind !== 2) begin n_fail++; $display("FAIL badidx_cause got %0d want 2", o.kind); end
    n_checks++; if (o.res !== 2) begin n_fail++; $display("FAIL badidx_cycle got %0d want 2", o.res); end
    n_checks++;
    if (o.pulses !== 0 || o.clrs !== 0) begin
      n_fail++; $display("FAIL badidx_strobes got steps=%0d clr=%0d want 0/0", o.pulses, o.clrs);
    end
    n_checks++;
    if (o.va !== 32'hABCD || o.vd !== 32'h99) begin
      n_fail++; $display("FAIL badidx_capture got %h/%h want 0000abcd/00000099", o.va, o.vd);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_event(8'd3, 32'h3000, 32'h50, o);
    n_checks++; if (o.kind !== 3) begin n_fail++; $display("FAIL timeout_cause got %0d want 3", o.kind); end
    n_checks++; if (o.res !== 11) begin n_fail++; $display("FAIL timeout_cycle got %0d want 11", o.res); end
    n_checks++; if (o.pulses !== 4) begin n_fail++; $display("FAIL timeout_steps got %0d want 4", o.pulses); end
  endtask

  task automatic test_boundaries();
    obs_t o;
    obs_t e;
    logic [7:0]  idx [4] = '{8'd4, 8'd6, 8'd5, 8'd0};
    logic [31:0] ad  [4] = '{32'h4000, 32'h6000, 32'h5000, 32'h7000};
    logic [31:0] dd  [4] = '{32'h40, 32'h9, 32'h1, 32'h30};
    for (int i = 0; i < 4; i++) begin
      e = predict(int'(idx[i]), ad[i], dd[i]);
      run_event(idx[i], ad[i], dd[i], o);
      n_checks++;
      if (o.kind !== e.kind || o.res !== e.res || o.pulses !== e.pulses) begin
        n_fail++; $display("FAIL boundary_%0d got kind=%0d cyc=%0d steps=%0d want %0d/%0d/%0d",
                           i, o.kind, o.res, o.pulses, e.kind, e.res, e.pulses);
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    obs_t        e;
    logic [7:0]  idx;
    logic [31:0] a;
    logic [31:0] d;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 8; i++) begin
        tbl_n[i] = int'($urandom_range(0, 6));
        for (int j = 0; j < 8; j++) begin
          tbl_a[i][j]  = 32'h1000 * (1 + $urandom_range(0, 3));
          tbl_lo[i][j] = $urandom_range(1, 64);
          tbl_hi[i][j] = ($urandom_range(0, 7) == 0) ? tbl_lo[i][j] - 1 : tbl_lo[i][j] + $urandom_range(0, 64);
        end
      end
      idx = 8'($urandom_range(0, 8));
      a   = ($urandom_range(0, 7) == 0) ? 32'h9000 : 32'h1000 * (1 + $urandom_range(0, 3));
      d   = $urandom_range(0, 140);
      e = predict(int'(idx), a, d);
      run_event(idx, a, d, o);
      n_checks++;
      if (o.kind !== e.kind || o.res !== e.res || o.rdy !== e.rdy) begin
        n_fail++; $display("FAIL rand_%0d_result got kind=%0d cyc=%0d rdy=%0d want %0d/%0d/%0d",
                           it, o.kind, o.res, o.rdy, e.kind, e.res, e.rdy);
      end
      n_checks++;
      if (o.pulses !== e.pulses || o.clrs !== e.clrs || o.npass !== e.npass || o.srch_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand_%0d_strobes got steps=%0d clr=%0d pass=%0d srch=%0d want %0d/%0d/%0d/1",
                           it, o.pulses, o.clrs, o.npass, o.srch_ok, e.pulses, e.clrs, e.npass);
      end
      if (e.kind != 0) begin
        n_checks++;
        if (o.va !== a || o.vd !== d) begin
          n_fail++; $display("FAIL rand_%0d_capture got %h/%h want %h/%h", it, o.va, o.vd, a, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int srch_bad = 0;
    int rdy_first = -1;
    load_plan_tables();
    @(negedge clk); i_viol_ack = 1'b1;
    @(negedge clk); i_viol_ack = 1'b0;
    i_acc_valid = 1'b1; i_acc_idx = 8'd2; i_acc_addr = 32'h2000; i_acc_data = 32'h15;
    @(negedge clk);
    i_acc_idx = 8'd1; i_acc_addr = 32'h5000; i_acc_data = 32'h1234;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (o_addr_srch !== 8'd2) srch_bad++;
      if (o_acc_ready && rdy_first < 0) rdy_first = cyc;
      if (cyc == 7) begin
        n_checks++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL b2b_first_pass got %b want 1", o_pass); end
      end
      @(negedge clk);
    end
    n_checks++; if (srch_bad !== 0) begin n_fail++; $display("FAIL b2b_srch_hold got %0d bad cycles want 0", srch_bad); end
    n_checks++; if (rdy_first !== 8) begin n_fail++; $display("FAIL b2b_ready_cycle got %0d want 8", rdy_first); end
    n_checks++;
    if (o_addr_srch !== 8'd1 || o_clr !== 1'b0 || o_acc_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept got srch=%0d clr=%b rdy=%b want 1/0/0", o_addr_srch, o_clr, o_acc_ready);
    end
    i_acc_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (o_pass !== 1'b1) begin n_fail++; $display("FAIL b2b_second_pass got %b want 1", o_pass); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_violation_flag();
    @(negedge clk); i_viol_ack = 1'b1;
    @(negedge clk); i_viol_ack = 1'b0;
    i_acc_valid = 1'b1; i_acc_idx = 8'd9; i_acc_addr = 32'hDEAD0000; i_acc_data = 32'h77;
    @(negedge clk); i_acc_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_violation !== 1'b1 || o_viol_cause !== 2'd2) begin
      n_fail++; $display("FAIL flag_raise got viol=%b cause=%0d want 1/2", o_violation, o_viol_cause);
    end
`ifdef DFI_STICKY_VIOLATION_EN
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if (o_violation !== 1'b1) begin n_fail++; $display("FAIL sticky_hold_c%0d got 0 want 1", c); end
    end
    i_viol_ack = 1'b1;
    @(negedge clk); i_viol_ack = 1'b0;
    n_checks++; if (o_violation !== 1'b0) begin n_fail++; $display("FAIL sticky_ack got 1 want 0"); end
`else
    @(negedge clk);
    n_checks++; if (o_violation !== 1'b0) begin n_fail++; $display("FAIL pulse_width got 1 want 0"); end
`endif
    // Ack held across a new violation: the violation wins, then the ack clears it.
    i_viol_ack = 1'b1;
    i_acc_valid = 1'b1; i_acc_idx = 8'd7;
    @(negedge clk); i_acc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (o_violation !== 1'b1) begin n_fail++; $display("FAIL ack_collide_set got 0 want 1"); end
    @(negedge clk);
    n_checks++; if (o_violation !== 1'b0) begin n_fail++; $display("FAIL ack_collide_clear got 1 want 0"); end
    i_viol_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midway();
    int bad = 0;
    load_plan_tables();
    @(negedge clk);
    i_acc_valid = 1'b1; i_acc_idx = 8'd3; i_acc_addr = 32'h3000; i_acc_data = 32'h50;
    @(negedge clk); i_acc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_acc_ready, o_clr, o_srch_pulse, o_pass, o_violation} !== 5'b11000 || o_viol_cause !== 2'd0 || o_addr_srch !== 8'd0) begin
      n_fail++; $display("FAIL midreset_state got flags=%b cause=%0d srch=%0d want 11000/0/0",
                         {o_acc_ready, o_clr, o_srch_pulse, o_pass, o_violation}, o_viol_cause, o_addr_srch);
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_pass || o_violation || !o_acc_ready || o_srch_pulse) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet got %0d active cycles want 0", bad); end
  endtask

  initial begin
    load_plan_tables();
    test_reset();
    test_pass();
    test_nomatch();
    test_bad_index();
    test_timeout();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_violation_flag();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
